// File: rtl/multicyc_ctrl_pkg.sv
// Shared types for the EX-stage multi-cycle unit: opcodes, sequencer states, request/response.
package multicyc_ctrl_pkg;

  typedef enum logic [3:0] {
    OpNone, OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu, OpDiv, OpDivu, OpMthi, OpMtlo
  } oper_t;

  typedef enum logic [2:0] {StIdle, StMul, StAcc, StDiv, StDone} mc_state_t;

  // LO value written for a divide by zero; HI gets the dividend.
  localparam logic [31:0] MC_DIV_ZERO_LO = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        valid;
    oper_t       op;
    logic [31:0] reg0;
    logic [31:0] reg1;
  } multicyc_req_t;

  typedef struct packed {
    logic        ready;
    logic        hilo_we;
    logic [63:0] hilo;
  } multicyc_resp_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/multicyc_ctrl_div_iter.sv
// Unsigned restoring divider, one quotient bit per step. quot_o/rem_o show the values after
// the current step so the caller can capture the final result on the last step.
module multicyc_ctrl_div_iter #(
  parameter int unsigned Steps = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int unsigned CntW = $clog2(Steps + 1);

  logic [31:0]     quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [32:0]     trial;

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    trial  = {rem_q, quot_q[31]};
    if (start_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
      cnt_d  = '0;
    end else if (step_i) begin
      // trial can reach 33 bits, but trial - divisor always fits in 32
      if (trial >= {1'b0, dvs_q}) begin
        rem_d  = trial[31:0] - dvs_q;
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = trial[31:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign done_o = step_i && (cnt_q == CntW'(Steps - 1));
  assign quot_o = quot_d;
  assign rem_o  = rem_d;

endmodule

// File: rtl/multicyc_ctrl.sv
// EX-stage multi-cycle sequencer: MUL/MADD/MSUB, iterative DIV and zero-latency MTHI/MTLO,
// producing a single HI/LO write strobe and the pipeline stall.
module multicyc_ctrl
  import multicyc_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_STEPS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  oper_t       op,
  input  logic [31:0] reg0,
  input  logic [31:0] reg1,
  input  logic [63:0] hilo_i,
  input  logic        flush,
  input  logic        pipe_adv,
  output logic        ready,
  output logic        hilo_we,
  output logic [63:0] hilo_o
);

  localparam logic [7:0] MulLast = 8'(MUL_CYCLES - 1);

  mc_state_t   state_q, state_d;
  oper_t       op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        s0_q, s0_d, s1_q, s1_d, first_q, first_d;
  logic [63:0] hilo_q, hilo_d, result_q, result_d;

  logic        is_signed, div_start, div_step, div_done;
  logic [31:0] op_a, op_b, div_quot, div_rem;
  logic [63:0] prod, prod_signed;

  assign is_signed   = op inside {OpMult, OpMadd, OpMsub, OpDiv};
  assign op_a        = is_signed ? abs32(reg0) : reg0;
  assign op_b        = is_signed ? abs32(reg1) : reg1;
  assign prod        = 64'(a_q) * 64'(b_q);
  assign prod_signed = (s0_q ^ s1_q) ? -prod : prod;

  multicyc_ctrl_div_iter #(
    .Steps(DIV_STEPS)
  ) u_div (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (div_start),
    .step_i    (div_step),
    .dividend_i(op_a),
    .divisor_i (op_b),
    .done_o    (div_done),
    .quot_o    (div_quot),
    .rem_o     (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    hilo_d    = hilo_q;
    result_d  = result_q;
    first_d   = 1'b0;
    div_start = 1'b0;
    div_step  = 1'b0;
    ready     = 1'b1;
    hilo_we   = 1'b0;
    hilo_o    = result_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          case (op)
            OpMthi: begin
              hilo_we = 1'b1;
              hilo_o  = {reg0, hilo_i[31:0]};
            end
            OpMtlo: begin
              hilo_we = 1'b1;
              hilo_o  = {hilo_i[63:32], reg0};
            end
            OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu: begin
              ready   = 1'b0;
              op_d    = op;
              a_d     = op_a;
              b_d     = op_b;
              s0_d    = is_signed & reg0[31];
              s1_d    = is_signed & reg1[31];
              hilo_d  = hilo_i;
              cnt_d   = '0;
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
              ready = 1'b0;
              op_d  = op;
              s0_d  = is_signed & reg0[31];
              s1_d  = is_signed & reg1[31];
              cnt_d = '0;
              if (reg1 == '0) begin
                result_d = {reg0, MC_DIV_ZERO_LO};
                first_d  = 1'b1;
                state_d  = StDone;
              end else begin
                div_start = 1'b1;
                state_d   = StDiv;
              end
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        ready = 1'b0;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == MulLast) begin
          result_d = prod_signed;
          if (op_q inside {OpMadd, OpMaddu, OpMsub, OpMsubu}) begin
            state_d = StAcc;
          end else begin
            first_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StAcc: begin
        ready    = 1'b0;
        result_d = (op_q inside {OpMsub, OpMsubu}) ? hilo_q - result_q : hilo_q + result_q;
        first_d  = 1'b1;
        state_d  = StDone;
      end
      StDiv: begin
        ready    = 1'b0;
        div_step = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        if (div_done) begin
          result_d = {s0_q ? -div_rem : div_rem, (s0_q ^ s1_q) ? -div_quot : div_quot};
          first_d  = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        hilo_we = first_q;
        if (pipe_adv) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush kills whatever is in flight, including a pending DONE write.
    if (flush) begin
      state_d   = StIdle;
      ready     = 1'b1;
      hilo_we   = 1'b0;
      first_d   = 1'b0;
      div_start = 1'b0;
      result_d  = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpNone;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      hilo_q   <= '0;
      result_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      hilo_q   <= hilo_d;
      result_q <= result_d;
      first_q  <= first_d;
    end
  end

  // The request must stay asserted while an operation is in flight unless it is being flushed.
  assert property (@(posedge clk) disable iff (rst)
    (state_q inside {StMul, StAcc, StDiv} && !flush) |-> req_valid);

endmodule

// File: tb/tb_multicyc_ctrl.sv
// Directed self-checking bench for multicyc_ctrl with hand-computed HI/LO results and latencies.
module tb_multicyc_ctrl;
  import multicyc_ctrl_pkg::*;

  logic        clk, rst, req_valid, flush, pipe_adv;
  oper_t       op;
  logic [31:0] reg0, reg1;
  logic [63:0] hilo_i;
  logic        ready, hilo_we;
  logic [63:0] hilo_o;

  int n_tests = 0;
  int n_fail  = 0;

  multicyc_ctrl #(
    .MUL_CYCLES(3),
    .DIV_STEPS (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .op       (op),
    .reg0     (reg0),
    .reg1     (reg1),
    .hilo_i   (hilo_i),
    .flush    (flush),
    .pipe_adv (pipe_adv),
    .ready    (ready),
    .hilo_we  (hilo_we),
    .hilo_o   (hilo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Counts stall cycles until ready rises (bounded); hilo_i is scrambled after accept.
  task automatic wait_done(output int stall);
    stall = 0;
    #1;
    while (!ready && stall < 100) begin
      stall++;
      next();
      hilo_i = ~hilo_i;
      #1;
    end
  endtask

  task automatic issue(input oper_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h);
    req_valid = 1'b1;
    op        = o;
    reg0      = a;
    reg1      = b;
    hilo_i    = h;
  endtask

  int stall;
  int we_cnt;
  logic rdy_all;

  initial begin
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; pipe_adv = 1'b1;
    op = OpNone; reg0 = '0; reg1 = '0; hilo_i = '0;
    next(); next();
    rst = 1'b0;
    #1;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_we", 64'(hilo_we), 64'd0);
    chk("reset_hilo", hilo_o, 64'd0);

    // MULT -3 * 7
    next();
    issue(OpMult, 32'hFFFF_FFFD, 32'd7, 64'd0);
    wait_done(stall);
    chk("mult_stall", 64'(stall), 64'd4);
    chk("mult_we", 64'(hilo_we), 64'd1);
    chk("mult_hilo", hilo_o, 64'hFFFF_FFFF_FFFF_FFEB);
    req_valid = 1'b0;
    next(); #1;
    chk("mult_we_once", 64'(hilo_we), 64'd0);

    // MADDU wraps modulo 2^64
    issue(OpMaddu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1_0000_0000);
    wait_done(stall);
    chk("maddu_stall", 64'(stall), 64'd5);
    chk("maddu_hilo", hilo_o, 64'hFFFF_FFFF_0000_0001);
    req_valid = 1'b0;
    next();

    // MSUB 0 - 2*3
    issue(OpMsub, 32'd2, 32'd3, 64'd0);
    wait_done(stall);
    chk("msub_stall", 64'(stall), 64'd5);
    chk("msub_hilo", hilo_o, 64'hFFFF_FFFF_FFFF_FFFA);
    req_valid = 1'b0;
    next();

    // DIV -7 / 2
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 64'd0);
    wait_done(stall);
    chk("div_stall", 64'(stall), 64'd33);
    chk("div_hilo", hilo_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    req_valid = 1'b0;
    next();

    // DIVU 7 / 0
    issue(OpDivu, 32'd7, 32'd0, 64'd0);
    wait_done(stall);
    chk("divz_stall", 64'(stall), 64'd1);
    chk("divz_we", 64'(hilo_we), 64'd1);
    chk("divz_hilo", hilo_o, {32'd7, 32'hFFFF_FFFF});
    req_valid = 1'b0;
    next();

    // INT_MIN / -1
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
    wait_done(stall);
    chk("divmin_hilo", hilo_o, {32'd0, 32'h8000_0000});
    req_valid = 1'b0;
    next();

    // Flush a DIV after 10 cycles, then MTLO right away
    issue(OpDiv, 32'd100, 32'd3, 64'd0);
    for (int i = 0; i < 10; i++) next();
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(ready), 64'd1);
    chk("flush_we", 64'(hilo_we), 64'd0);
    next();
    flush = 1'b0;
    issue(OpMtlo, 32'h0000_1234, 32'd0, 64'hAAAA_BBBB_CCCC_DDDD);
    #1;
    chk("mtlo_after_flush_ready", 64'(ready), 64'd1);
    chk("mtlo_after_flush_we", 64'(hilo_we), 64'd1);
    chk("mtlo_after_flush_hilo", hilo_o, 64'hAAAA_BBBB_0000_1234);
    req_valid = 1'b0;
    next();

    // Flush and MTHI together in IDLE: request ignored
    issue(OpMthi, 32'h5, 32'd0, 64'd0);
    flush = 1'b1;
    #1;
    chk("flush_mthi_we", 64'(hilo_we), 64'd0);
    next();
    flush = 1'b0; req_valid = 1'b0;

    // MULT held in DONE by pipe_adv=0
    pipe_adv = 1'b0;
    issue(OpMult, 32'd5, 32'd6, 64'd0);
    wait_done(stall);
    req_valid = 1'b0;
    #1;
    we_cnt = 0; rdy_all = 1'b1;
    for (int i = 0; i < 5; i++) begin
      we_cnt += int'(hilo_we);
      rdy_all &= ready;
      next();
    end
    chk("hold_we_count", 64'(we_cnt), 64'd1);
    chk("hold_ready", 64'(rdy_all), 64'd1);
    chk("hold_hilo", hilo_o, 64'd30);
    pipe_adv = 1'b1;
    next();
    issue(OpMthi, 32'hCAFE, 32'd0, 64'h1111_2222_3333_4444);
    #1;
    chk("idle_after_adv_we", 64'(hilo_we), 64'd1);
    chk("idle_after_adv_hilo", hilo_o, 64'h0000_CAFE_3333_4444);
    req_valid = 1'b0;
    next();

    // Flush on the DONE strobe cycle suppresses the write
    issue(OpMult, 32'd2, 32'd2, 64'd0);
    wait_done(stall);
    flush = 1'b1;
    #1;
    chk("done_flush_we", 64'(hilo_we), 64'd0);
    chk("done_flush_ready", 64'(ready), 64'd1);
    next();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("done_flush_no_late_we", 64'(hilo_we), 64'd0);

    // Reset mid-DIV
    issue(OpDiv, 32'd1000, 32'd7, 64'd0);
    for (int i = 0; i < 5; i++) next();
    rst = 1'b1; req_valid = 1'b0;
    next();
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(ready), 64'd1);
    chk("rst_mid_we", 64'(hilo_we), 64'd0);
    chk("rst_mid_hilo", hilo_o, 64'd0);

    // Back-to-back MTHI, MTLO
    next();
    issue(OpMthi, 32'hAAAA_0001, 32'd0, 64'h0123_4567_89AB_CDEF);
    #1;
    chk("b2b_mthi_we", 64'(hilo_we), 64'd1);
    chk("b2b_mthi_hilo", hilo_o, 64'hAAAA_0001_89AB_CDEF);
    next();
    issue(OpMtlo, 32'hBBBB_0002, 32'd0, 64'h0123_4567_89AB_CDEF);
    #1;
    chk("b2b_mtlo_we", 64'(hilo_we), 64'd1);
    chk("b2b_mtlo_hilo", hilo_o, 64'h0123_4567_BBBB_0002);
    next();
    req_valid = 1'b0;
    #1;
    chk("b2b_idle_we", 64'(hilo_we), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
